// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : clock_pkg
//  Purpose : Shared definitions for the clock-generation / reset-sequencing
//            logic. Holds the lock-manager state encoding so that the status
//            decoder and the lock manager agree on it.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package clock_pkg;

    localparam int LM_STATE_W = 3;

    typedef enum logic [LM_STATE_W-1:0] {
        LM_RESET_PLL = 3'd0,
        LM_WAIT_LOCK = 3'd1,
        LM_STABILISE = 3'd2,
        LM_RUN       = 3'd3,
        LM_FAULT     = 3'd4
    } lm_state_t;

endpackage : clock_pkg
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
//  Module  : sync_bit
//  Purpose : Multi-flop synchroniser for a single asynchronous level signal.
//            Flops clear to 0 on reset.
//  Ports   : clk    in  destination clock
//            rst_n  in  asynchronous active-low reset
//            d_i    in  asynchronous input level
//            q_o    out synchronised level (last stage)
//  Rev     : 1.0  initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : sync_bit
`default_nettype wire

// File: rtl/pll_lock_mgr.sv
`default_nettype none
// ============================================================================
//  Module  : pll_lock_mgr
//  Purpose : PLL lock manager running on the free-running board oscillator.
//            Pulses PLL reset, waits for lock with a timeout, requires lock to
//            be stable, then releases the system reset. Bounded retries, after
//            which a fault is latched until restart or rst_n.
//  Ports   : clk           in  board oscillator clock
//            rst_n         in  asynchronous active-low reset
//            pll_locked_i  in  raw PLL LOCK (asynchronous to clk)
//            restart_i     in  synchronous restart request
//            pll_rst_o     out PLL reset, active high
//            sys_rst_o     out system reset request, active high
//            ready_o       out clocks locked and stable
//            fault_o       out retries exhausted
//            retries_o     out consecutive timeout count
//            loss_count_o  out saturating count of lock losses while running
//  Rev     : 1.0  initial release
// ============================================================================
module pll_lock_mgr
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int RST_PULSE    = 16,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int STABLE_CNT   = 1024,
    parameter int RETRY_MAX    = 7,
    parameter int CNT_W        = 24,
    parameter int ERR_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked_i,
    input  logic             restart_i,
    output logic             pll_rst_o,
    output logic             sys_rst_o,
    output logic             ready_o,
    output logic             fault_o,
    output logic [2:0]       retries_o,
    output logic [ERR_W-1:0] loss_count_o
);

    // Terminal counts: an exit fires on the cycle the counter shows N-1.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [2:0]       RETRY_LIM   = 3'(RETRY_MAX);

    logic             locked_s;

    lm_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       retries_q, retries_d;
    logic [ERR_W-1:0] loss_q, loss_d;
    logic             pll_rst_q, sys_rst_q, ready_q, fault_q;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_locked_i),
        .q_o   (locked_s)
    );

    // Next-state logic. Every transition (including a restart re-entering
    // RESET_PLL) clears the counter. RUN and FAULT have no timed exit, so the
    // counter is parked there instead of free-running into a wrap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        retries_d = retries_q;
        loss_d    = loss_q;

        if (restart_i) begin
            state_d   = LM_RESET_PLL;
            cnt_d     = '0;
            retries_d = '0;
        end else begin
            case (state_q)
                LM_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = LM_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                LM_WAIT_LOCK: begin
                    // Lock wins over a coincident timeout.
                    if (locked_s) begin
                        state_d = LM_STABILISE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retries_d = retries_q + 3'd1;
                        state_d   = (retries_d == RETRY_LIM) ? LM_FAULT : LM_RESET_PLL;
                        cnt_d     = '0;
                    end
                end
                LM_STABILISE: begin
                    // A glitch returns to waiting without re-resetting the PLL.
                    if (!locked_s) begin
                        state_d = LM_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d   = LM_RUN;
                        cnt_d     = '0;
                        retries_d = '0;
                    end
                end
                LM_RUN: begin
                    cnt_d = '0;
                    if (!locked_s) begin
                        state_d = LM_RESET_PLL;
                        if (loss_q != '1) begin
                            loss_d = loss_q + ERR_W'(1);
                        end
                    end
                end
                LM_FAULT: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = LM_RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with the state register and never depend combinationally on inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LM_RESET_PLL;
            cnt_q     <= '0;
            retries_q <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            loss_q    <= loss_d;
            pll_rst_q <= (state_d == LM_RESET_PLL);
            sys_rst_q <= (state_d != LM_RUN);
            ready_q   <= (state_d == LM_RUN);
            fault_q   <= (state_d == LM_FAULT);
        end
    end

    assign pll_rst_o    = pll_rst_q;
    assign sys_rst_o    = sys_rst_q;
    assign ready_o      = ready_q;
    assign fault_o      = fault_q;
    assign retries_o    = retries_q;
    assign loss_count_o = loss_q;

endmodule : pll_lock_mgr
`default_nettype wire
